// File: rtl/tick_generator_if.sv
// tick_generator_if
//   Groups the pushbutton inputs and tick/status outputs of tick_generator.
//   KEY_RUN_N   raw run/stop key, active-low, asynchronous
//   KEY_STEP_N  raw single-step key, active-low, asynchronous
//   count_pulse one-cycle tick to downstream counter
//   running     run-state LED
//   master: board/bench side (drives keys); slave: tick_generator side.
interface tick_generator_if;
  logic KEY_RUN_N;
  logic KEY_STEP_N;
  logic count_pulse;
  logic running;

  modport master (output KEY_RUN_N, output KEY_STEP_N,
                  input  count_pulse, input running);
  modport slave  (input  KEY_RUN_N, input KEY_STEP_N,
                  output count_pulse, output running);
endinterface

// File: rtl/tick_generator.sv
// tick_generator
//   Rate-controlled pulse source for the 7-segment counter chain.
//   Synchronizes (and optionally debounces) two active-low keys, turns a
//   debounced press into a one-cycle strobe, and runs a STOPPED/RUNNING FSM
//   that emits free-running ticks every DIV = CLK_HZ/TICK_HZ cycles or a
//   single tick per step press.
//   Ports:
//     CLOCK_50  clock, rising edge
//     RST_N     asynchronous active-low reset
//     io        tick_generator_if.slave (keys in, count_pulse/running out)
//   Build option: define TICK_DEBOUNCE_EN to include the debounce filters;
//   without it the synchronized key level feeds the edge detector directly
//   and DEBOUNCE_CYCLES/DB_W are unused.
module tick_generator #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned TICK_HZ         = 1,
  parameter int unsigned DIV_W           = 26,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DB_W            = 20
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  tick_generator_if.slave  io
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;

  typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

  // Bit 0: run key, bit 1: step key.
  logic [1:0] raw;
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] lvl;
  logic [1:0] lvl_prev_q, lvl_prev_d;
  logic [1:0] press_q, press_d;

  assign raw = {io.KEY_STEP_N, io.KEY_RUN_N};

  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    lvl_prev_d = lvl;
    // Strobe lags the level change by one cycle: it compares the two most
    // recent registered levels rather than the next-state level.
    press_d    = lvl_prev_q & ~lvl;
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      lvl_prev_q <= '1;
      press_q    <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      lvl_prev_q <= lvl_prev_d;
      press_q    <= press_d;
    end
  end

`ifdef TICK_DEBOUNCE_EN
  logic [1:0]      db_q, db_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];

  always_comb begin
    db_d = db_q;
    for (int unsigned i = 0; i < 2; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d[i]     = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      db_q        <= '1;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      db_q        <= db_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  assign lvl = db_q;
`else
  localparam int unsigned UNUSED_DB = DEBOUNCE_CYCLES + DB_W;
  assign lvl = sync2_q;
`endif

  logic run_press, step_press;
  assign run_press  = press_q[0];
  assign step_press = press_q[1];

  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             pulse_q, pulse_d;
  logic             running_q, running_d;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    pulse_d = 1'b0;
    case (state_q)
      STOPPED: begin
        presc_d = '0;
        // Run press takes priority; a simultaneous step press is dropped.
        if (run_press) begin
          state_d = RUNNING;
        end else if (step_press) begin
          pulse_d = 1'b1;
        end
      end
      RUNNING: begin
        if (run_press) begin
          state_d = STOPPED;
          presc_d = '0;
        end else if (presc_q == DIV_W'(DIV - 1)) begin
          presc_d = '0;
          pulse_d = 1'b1;
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      default: state_d = STOPPED;
    endcase
    running_d = (state_d == RUNNING);
  end

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= STOPPED;
      presc_q   <= '0;
      pulse_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      pulse_q   <= pulse_d;
      running_q <= running_d;
    end
  end

  assign io.count_pulse = pulse_q;
  assign io.running     = running_q;

endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator
//   Drives tick_generator with directed key sequences and random key
//   activity. A cycle-level behavioural model (key history windows, toggle
//   flag, tick phase from run-start time) predicts count_pulse and running;
//   they are compared every cycle, plus literal latency/count expectations.
module tb_tick_generator;

  localparam int DIV = 10;
  localparam int DEB = 4;
`ifdef TICK_DEBOUNCE_EN
  localparam int LAT = 2 + DEB + 1;   // key edge to press strobe
`else
  localparam int LAT = 3;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  tick_generator_if io();

  tick_generator #(
    .CLK_HZ(100), .TICK_HZ(10), .DIV_W(4), .DEBOUNCE_CYCLES(4), .DB_W(3)
  ) dut (
    .CLOCK_50(clk),
    .RST_N   (rst_n),
    .io      (io)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] hist [2];            // raw key samples, bit 0 = newest
  logic [1:0] lvl1 = '1, lvl2 = '1, str = '0;
  bit         m_running = 1'b0, m_pulse = 1'b0;
  int         cyc = 0, r = 0;

  task automatic model_reset();
    hist[0] = '1; hist[1] = '1;
    lvl1 = '1; lvl2 = '1; str = '0;
    m_running = 1'b0; m_pulse = 1'b0; r = 0;
  endtask

  task automatic model_step();
    logic [1:0] keys, nlvl, nstr;
    bit stable;
    keys = {io.KEY_STEP_N, io.KEY_RUN_N};
    cyc++;
    m_pulse = 1'b0;
    if (m_running) begin
      if (str[0]) m_running = 1'b0;
      else if ((cyc - r) % DIV == 0) m_pulse = 1'b1;
    end else begin
      if (str[0]) begin m_running = 1'b1; r = cyc; end
      else if (str[1]) m_pulse = 1'b1;
    end
    nstr = lvl2 & ~lvl1;
    nlvl = lvl1;
    for (int k = 0; k < 2; k++) begin
      hist[k] = {hist[k][6:0], keys[k]};
`ifdef TICK_DEBOUNCE_EN
      // Level follows a value only after DEB consecutive synchronized samples.
      stable = 1'b1;
      for (int j = 3; j <= DEB + 1; j++)
        if (hist[k][j] != hist[k][2]) stable = 1'b0;
      if (stable) nlvl[k] = hist[k][2];
`else
      stable = 1'b1;
      nlvl[k] = hist[k][1] & stable;
`endif
    end
    lvl2 = lvl1; lvl1 = nlvl; str = nstr;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  int shown = 0;
  always @(negedge clk) begin
    checks += 2;
    if (io.count_pulse !== m_pulse) begin
      failures++;
      if (shown++ < 30)
        $display("FAIL model_pulse t=%0t got=%0b exp=%0b", $time, io.count_pulse, m_pulse);
    end
    if (io.running !== m_running) begin
      failures++;
      if (shown++ < 30)
        $display("FAIL model_running t=%0t got=%0b exp=%0b", $time, io.running, m_running);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lcheck(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic count_pulses(int n, output int np);
    np = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (io.count_pulse) np++;
    end
  endtask

  task automatic wait_pulse(string nm);
    int seen = 0;
    for (int k = 0; k < 60 && seen == 0; k++) begin
      @(negedge clk);
      if (io.count_pulse) seen = 1;
    end
    lcheck(nm, seen, 1);
  endtask

  // Press run for 10 cycles; report first running/pulse cycle and pulses in
  // the 50 cycles starting at the first pulse.
  task automatic measure(output int fr, output int fp, output int np);
    fr = -1; fp = -1; np = 0;
    io.KEY_RUN_N = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 10) io.KEY_RUN_N = 1'b1;
      if (io.running && fr < 0) fr = k;
      if (io.count_pulse) begin
        if (fp < 0) fp = k;
        if (k < fp + 50) np++;
      end
    end
  endtask

  task automatic press_run(int hold);
    io.KEY_RUN_N = 1'b0; tick(hold); io.KEY_RUN_N = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int fr, fp, np, last, bad;

  initial begin
    io.KEY_RUN_N = 1'b0;
    io.KEY_STEP_N = 1'b0;

    // Reset held with both keys pressed
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      lcheck("reset_pulse", int'(io.count_pulse), 0);
      lcheck("reset_running", int'(io.running), 0);
    end
    io.KEY_RUN_N = 1'b1; io.KEY_STEP_N = 1'b1;
    #2 rst_n = 1'b1;
    count_pulses(100, np);
    lcheck("idle_pulses", np, 0);

    // Run
    measure(fr, fp, np);
    lcheck("run_latency", fr, LAT + 1);
    lcheck("first_pulse", fp, LAT + 1 + DIV);
    lcheck("pulses_in_50", np, 5);

    // Step while running: period unaffected
    io.KEY_STEP_N = 1'b0;
    last = -1; bad = 0; np = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k % 20 == 6) io.KEY_STEP_N = 1'b1;
      if (k % 20 == 0) io.KEY_STEP_N = 1'b0;
      if (io.count_pulse) begin
        np++;
        if (last >= 0 && k - last != DIV) bad++;
        last = k;
      end
    end
    io.KEY_STEP_N = 1'b1;
    lcheck("run_step_count", np, 6);
    lcheck("run_step_gaps", bad, 0);
    tick(20);

    // Stop with strobe landing at prescaler = 7
    wait_pulse("wait_pulse_stop");
    tick(7 - LAT);
    press_run(6);
    count_pulses(20, np);
    lcheck("stop_pulses", np, 0);
    lcheck("stop_running", int'(io.running), 0);

    // Restart: first pulse DIV+1 after the strobe
    measure(fr, fp, np);
    lcheck("restart_first", fp - LAT, DIV + 1);
    press_run(6);
    tick(20);
    lcheck("stopped_again", int'(io.running), 0);

    // Bounce rejection
    io.KEY_RUN_N = 1'b0; tick(2);
    io.KEY_RUN_N = 1'b1; tick(1);
    io.KEY_RUN_N = 1'b0; tick(2);
    io.KEY_RUN_N = 1'b1; tick(20);
    lcheck("bounce_running", int'(io.running), 0);
    press_run(6);
    tick(12);
    lcheck("clean_running", int'(io.running), 1);
    press_run(6);
    tick(20);

    // Single steps while stopped
    io.KEY_STEP_N = 1'b0;
    fp = -1; np = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k % 20 == 6) io.KEY_STEP_N = 1'b1;
      if (k % 20 == 0) io.KEY_STEP_N = 1'b0;
      if (io.count_pulse) begin
        np++;
        if (fp < 0) fp = k;
      end
    end
    io.KEY_STEP_N = 1'b1;
    lcheck("step_count", np, 3);
    lcheck("step_latency", fp, LAT + 1);
    tick(20);

    // Run and step together: run wins
    io.KEY_RUN_N = 1'b0; io.KEY_STEP_N = 1'b0;
    np = 0;
    for (int k = 1; k <= LAT + DIV; k++) begin
      @(negedge clk);
      if (k == 6) begin io.KEY_RUN_N = 1'b1; io.KEY_STEP_N = 1'b1; end
      if (io.count_pulse) np++;
    end
    lcheck("simul_pulses", np, 0);
    lcheck("simul_running", int'(io.running), 1);

    // Reset at prescaler = 9
    wait_pulse("wait_pulse_reset");
    tick(9);
    #2 rst_n = 1'b0;
    #1;
    lcheck("async_running", int'(io.running), 0);
    lcheck("async_pulse", int'(io.count_pulse), 0);
    tick(3);
    #2 rst_n = 1'b1;
    count_pulses(20, np);
    lcheck("post_reset_pulses", np, 0);

    // Random key activity with occasional short resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, (c < 1000) ? 6 : 24) == 0) io.KEY_RUN_N = ~io.KEY_RUN_N;
      if ($urandom_range(0, (c < 1000) ? 5 : 20) == 0) io.KEY_STEP_N = ~io.KEY_STEP_N;
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    io.KEY_RUN_N = 1'b1; io.KEY_STEP_N = 1'b1;
    tick(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
